// File: rtl/frogger_game_fsm_if.sv
// rtl/frogger_game_fsm_if.sv - game sequencer signal bundle between datapath and frogger_game_fsm
interface frogger_game_fsm_if;
  logic       i_Frame_Tick;
  logic       i_Game_Start;
  logic       i_Collided;
  logic [5:0] i_Frogger_Y;
  logic [1:0] o_State;
  logic       o_Game_Active;
  logic       o_Frog_Reset;
  logic [1:0] o_Lives;
  logic [6:0] o_Score;
  logic       o_Game_Over;
  logic       o_Invuln;

  modport master (
    output i_Frame_Tick, i_Game_Start, i_Collided, i_Frogger_Y,
    input  o_State, o_Game_Active, o_Frog_Reset, o_Lives, o_Score, o_Game_Over, o_Invuln
  );

  modport slave (
    input  i_Frame_Tick, i_Game_Start, i_Collided, i_Frogger_Y,
    output o_State, o_Game_Active, o_Frog_Reset, o_Lives, o_Score, o_Game_Over, o_Invuln
  );
endinterface

// File: rtl/frogger_game_fsm.sv
// rtl/frogger_game_fsm.sv - Frogger game sequencer: state, lives, score, grace period and respawn pulse
module frogger_game_fsm #(
  parameter int c_LIVES        = 3,
  parameter int c_GOAL_ROW     = 0,
  parameter int c_WIN_SCORE    = 5,
  parameter int c_GRACE_FRAMES = 60,
  parameter int c_HOLD_FRAMES  = 180
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  frogger_game_fsm_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_P1_WINS = 2'b10,
    ST_CLEANUP = 2'b11
  } state_e;

  localparam logic [1:0] LIVES_INIT = 2'(c_LIVES);
  localparam logic [5:0] GOAL_ROW   = 6'(c_GOAL_ROW);
  localparam logic [6:0] WIN_SCORE  = 7'(c_WIN_SCORE);
  localparam logic [6:0] SCORE_MAX  = 7'd99;
  localparam logic [7:0] GRACE_INIT = 8'(c_GRACE_FRAMES);
  localparam logic [7:0] HOLD_INIT  = 8'(c_HOLD_FRAMES);

  state_e     state_q, state_d;
  logic [1:0] lives_q, lives_d;
  logic [6:0] score_q, score_d;
  logic       game_over_q, game_over_d;
  logic       invuln_q, invuln_d;
  logic       frog_reset_q, frog_reset_d;
  logic       game_active_q, game_active_d;
  logic [7:0] grace_q, grace_d;
  logic [7:0] hold_q, hold_d;
  logic       start_prev_q, start_prev_d;
  logic       coll_prev_q, coll_prev_d;
  logic       goal_prev_q, goal_prev_d;

  logic       goal_now;
  logic       start_rise;
  logic       coll_rise;
  logic       goal_rise;
  logic [6:0] score_inc;

  assign goal_now   = (bus.i_Frogger_Y == GOAL_ROW);
  assign start_rise = bus.i_Game_Start & ~start_prev_q;
  assign coll_rise  = bus.i_Collided & ~coll_prev_q;
  assign goal_rise  = goal_now & ~goal_prev_q;
  assign score_inc  = (score_q >= SCORE_MAX) ? SCORE_MAX : score_q + 7'd1;

  always_comb begin
    state_d       = state_q;
    lives_d       = lives_q;
    score_d       = score_q;
    game_over_d   = game_over_q;
    invuln_d      = invuln_q;
    frog_reset_d  = 1'b0;
    grace_d       = grace_q;
    hold_d        = hold_q;
    start_prev_d  = bus.i_Game_Start;
    coll_prev_d   = bus.i_Collided;
    goal_prev_d   = goal_now;

    // Grace runs on frames regardless of state; CLEANUP and new hits override it below.
    if (invuln_q && bus.i_Frame_Tick) begin
      grace_d = grace_q - 8'd1;
      if (grace_q <= 8'd1) begin
        invuln_d = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d      = ST_RUNNING;
          lives_d      = LIVES_INIT;
          score_d      = 7'd0;
          game_over_d  = 1'b0;
          invuln_d     = 1'b0;
          grace_d      = 8'd0;
          frog_reset_d = 1'b1;
        end
      end
      ST_RUNNING: begin
        if (coll_rise && !invuln_q) begin
          frog_reset_d = 1'b1;
          if (lives_q != 2'd0) begin
            lives_d = lives_q - 2'd1;
          end
          if (lives_q <= 2'd1) begin
            game_over_d = 1'b1;
            state_d     = ST_CLEANUP;
            invuln_d    = 1'b0;
            grace_d     = 8'd0;
          end else begin
            invuln_d = 1'b1;
            grace_d  = GRACE_INIT;
          end
        end else if (goal_rise) begin
          score_d      = score_inc;
          frog_reset_d = 1'b1;
          if (score_inc == WIN_SCORE) begin
            state_d = ST_P1_WINS;
            hold_d  = HOLD_INIT;
          end
        end
      end
      ST_P1_WINS: begin
        if (bus.i_Frame_Tick) begin
          if (hold_q <= 8'd1) begin
            hold_d  = 8'd0;
            state_d = ST_CLEANUP;
          end else begin
            hold_d = hold_q - 8'd1;
          end
        end
      end
      ST_CLEANUP: begin
        frog_reset_d = 1'b1;
        lives_d      = LIVES_INIT;
        invuln_d     = 1'b0;
        grace_d      = 8'd0;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    game_active_d = (state_d == ST_RUNNING);
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q       <= ST_IDLE;
      lives_q       <= LIVES_INIT;
      score_q       <= 7'd0;
      game_over_q   <= 1'b0;
      invuln_q      <= 1'b0;
      frog_reset_q  <= 1'b0;
      game_active_q <= 1'b0;
      grace_q       <= 8'd0;
      hold_q        <= 8'd0;
      start_prev_q  <= 1'b0;
      coll_prev_q   <= 1'b0;
      goal_prev_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      score_q       <= score_d;
      game_over_q   <= game_over_d;
      invuln_q      <= invuln_d;
      frog_reset_q  <= frog_reset_d;
      game_active_q <= game_active_d;
      grace_q       <= grace_d;
      hold_q        <= hold_d;
      start_prev_q  <= start_prev_d;
      coll_prev_q   <= coll_prev_d;
      goal_prev_q   <= goal_prev_d;
    end
  end

  assign bus.o_State       = state_q;
  assign bus.o_Game_Active = game_active_q;
  assign bus.o_Frog_Reset  = frog_reset_q;
  assign bus.o_Lives       = lives_q;
  assign bus.o_Score       = score_q;
  assign bus.o_Game_Over   = game_over_q;
  assign bus.o_Invuln      = invuln_q;

endmodule
